// File: rtl/hssl_pkt_framer_if.sv
// ----------------------------------------------------------------------------
// hssl_pkt_framer_if
// Bundles the event-path packet handshake and the transceiver TX word port of
// the HSSL packet framer.
//
// Handshake semantics: a packet transfers on a clock edge where
// pkt_vld & pkt_rdy are both high. pkt_vld may be raised at any time and the
// data must stay stable until it is taken. pkt_rdy never looks at pkt_vld.
// tx_rdy is the transceiver word strobe: one TX word is loaded per tx_rdy=1
// cycle, and nothing moves on tx_rdy=0 cycles.
//
// Signals
//   pkt_data   [71:0] [7:0] hdr, [39:8] key, [71:40] payload (valid iff hdr[1])
//   pkt_vld           packet valid (source -> framer)
//   pkt_rdy           packet ready (framer -> source)
//   tx_rdy            transceiver word strobe (GT -> framer)
//   tx_data    [31:0] registered TX word (framer -> GT)
//   tx_charisk [3:0]  registered K-char flags (framer -> GT)
//   frame_sent        registered pulse when an EOF word is loaded
// Modports: master = packet source / TX sink side, slave = framer.
// ----------------------------------------------------------------------------
interface hssl_pkt_framer_if;
   logic [71:0] pkt_data;
   logic        pkt_vld;
   logic        pkt_rdy;
   logic        tx_rdy;
   logic [31:0] tx_data;
   logic [3:0]  tx_charisk;
   logic        frame_sent;

   modport master (
      output pkt_data, pkt_vld, tx_rdy,
      input  pkt_rdy, tx_data, tx_charisk, frame_sent
   );

   modport slave (
      input  pkt_data, pkt_vld, tx_rdy,
      output pkt_rdy, tx_data, tx_charisk, frame_sent
   );
endinterface

// File: rtl/hssl_pkt_framer.sv
// ----------------------------------------------------------------------------
// hssl_pkt_framer
// Packs SpiNNaker multicast packets (40/72-bit) into framed 32-bit words for
// the HSSL transceiver TX data port. A frame is SOF, then HDR/KEY[/PLD] words
// per packet, then an EOF carrying a 16-bit checksum and the packet count.
// Frames close when FRAME_PKTS packets are in, or after TIMEOUT idle words in
// an open frame. Every unused transceiver slot carries IDLE_WORD (K28.5).
//
// Ports
//   clk        GT TX user clock
//   reset      synchronous, active-high
//   bus        hssl_pkt_framer_if.slave (packet handshake + TX word port)
//   dbg_state  current FSM state, for observation only
// ----------------------------------------------------------------------------
module hssl_pkt_framer #(
   parameter int          FRAME_PKTS = 16,
   parameter int          TIMEOUT    = 64,
   parameter logic [31:0] IDLE_WORD  = 32'h4A4A_4ABC
) (
   input  logic                   clk,
   input  logic                   reset,
   hssl_pkt_framer_if.slave       bus,
   output logic [2:0]             dbg_state
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_KEY  = 3'd2,
      S_PLD  = 3'd3,
      S_WAIT = 3'd4,
      S_EOF  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [71:0]   hold_q, hold_d;
   logic [7:0]    count_q, count_d;
   logic [15:0]   csum_q, csum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [31:0]   tx_data_q, tx_data_d;
   logic [3:0]    tx_charisk_q, tx_charisk_d;
   logic          frame_sent_q, frame_sent_d;

   logic          last_word;
   logic          accept;

   function automatic logic [15:0] csum_add(input logic [15:0] c, input logic [31:0] w);
      return c + w[15:0] + w[31:16];
   endfunction

   // The word being loaded this cycle is the last of its packet: the PLD
   // word, or the KEY word of a packet without payload.
   assign last_word = (state_q == S_PLD) || ((state_q == S_KEY) && !hold_q[1]);

   assign bus.pkt_rdy = bus.tx_rdy && !reset &&
                        ((state_q == S_IDLE) || (state_q == S_WAIT) ||
                         (last_word && (count_q < 8'(FRAME_PKTS))));
   assign accept      = bus.pkt_rdy && bus.pkt_vld;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      count_d      = count_q;
      csum_d       = csum_q;
      tmo_d        = tmo_q;
      tx_data_d    = tx_data_q;
      tx_charisk_d = tx_charisk_q;
      frame_sent_d = frame_sent_q;

      if (bus.tx_rdy) begin
         tx_charisk_d = 4'b0000;
         frame_sent_d = 1'b0;
         if (accept) begin
            hold_d  = bus.pkt_data;
            count_d = count_q + 8'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  tx_data_d    = {24'h0, 8'hFB};
                  tx_charisk_d = 4'b0001;
                  count_d      = 8'd1;  // new frame: this packet is the first
                  csum_d       = 16'h0;
                  state_d      = S_HDR;
               end else begin
                  tx_data_d    = IDLE_WORD;
                  tx_charisk_d = 4'b0001;
               end
            end
            S_HDR: begin
               tx_data_d = {24'h0, hold_q[7:0]};
               csum_d    = csum_add(csum_q, {24'h0, hold_q[7:0]});
               state_d   = S_KEY;
            end
            S_KEY, S_PLD: begin
               tx_data_d = (state_q == S_PLD) ? hold_q[71:40] : hold_q[39:8];
               csum_d    = csum_add(csum_q, tx_data_d);
               if (!last_word) begin
                  state_d = S_PLD;
               end else if (count_q == 8'(FRAME_PKTS)) begin
                  state_d = S_EOF;
               end else if (accept) begin
                  state_d = S_HDR;
               end else begin
                  tmo_d   = '0;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (accept) begin
                  // HDR comes straight from the input: the hold register is
                  // only being written this cycle.
                  tx_data_d = {24'h0, bus.pkt_data[7:0]};
                  csum_d    = csum_add(csum_q, {24'h0, bus.pkt_data[7:0]});
                  state_d   = S_KEY;
               end else begin
                  tx_data_d    = IDLE_WORD;
                  tx_charisk_d = 4'b0001;
                  if (tmo_q == TW'(TIMEOUT - 1)) begin
                     state_d = S_EOF;
                  end else begin
                     tmo_d = tmo_q + 1'b1;
                  end
               end
            end
            S_EOF: begin
               tx_data_d    = {csum_q, count_q, 8'hFD};
               tx_charisk_d = 4'b0001;
               frame_sent_d = 1'b1;
               state_d      = S_IDLE;
            end
            default: begin
               tx_data_d    = IDLE_WORD;
               tx_charisk_d = 4'b0001;
               state_d      = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         count_q      <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
         tx_data_q    <= IDLE_WORD;
         tx_charisk_q <= 4'b0001;
         frame_sent_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         count_q      <= count_d;
         csum_q       <= csum_d;
         tmo_q        <= tmo_d;
         tx_data_q    <= tx_data_d;
         tx_charisk_q <= tx_charisk_d;
         frame_sent_q <= frame_sent_d;
      end
   end

   assign bus.tx_data    = tx_data_q;
   assign bus.tx_charisk = tx_charisk_q;
   assign bus.frame_sent = frame_sent_q;
   assign dbg_state      = state_q;

endmodule
